// File: rtl/vector_ring_buffer.sv
// ----------------------------------------------------------------------------
// vector_ring_buffer
//   Assembles IN_W-bit input beats into VEC_W-bit vectors and keeps up to
//   NB_VECTORS complete vectors in a ring. One vector is served per request,
//   registered, one cycle after the request edge.
//
// Ports
//   clk       in   1      clock, all state updates on posedge
//   rst       in   1      synchronous reset, active-high (overrides all)
//   flush     in   1      drop every stored vector and any partial vector
//   in_data   in   IN_W   input beat
//   in_valid  in   1      in_data valid this cycle
//   in_ready  out  1      beat accepted when in_valid && in_ready
//   req       in   1      request one vector
//   vector    out  VEC_W  registered output vector (0 when not valid)
//   valid     out  1      registered: vector holds a real entry
//   count     out  CNT_W  number of complete vectors stored
//   empty     out  1      count == 0
//   full      out  1      count == NB_VECTORS
//   drop      out  1      registered pulse: a beat was refused last cycle
// ----------------------------------------------------------------------------
module vector_ring_buffer #(
   parameter int unsigned VEC_W      = 8,
   parameter int unsigned NB_VECTORS = 8,
   parameter int unsigned IN_W       = 1,
   localparam int unsigned BEATS     = VEC_W / IN_W,
   localparam int unsigned PTR_W     = $clog2(NB_VECTORS),
   localparam int unsigned CNT_W     = PTR_W + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic [IN_W-1:0]  in_data,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             req,
   output logic [VEC_W-1:0] vector,
   output logic             valid,
   output logic [CNT_W-1:0] count,
   output logic             empty,
   output logic             full,
   output logic             drop
);

   // A single-beat vector still needs a 1-bit fill counter to stay legal.
   localparam int unsigned FILL_W = (BEATS > 1) ? $clog2(BEATS) : 1;

   logic [PTR_W-1:0]  prod_q, prod_d;
   logic [PTR_W-1:0]  cons_q, cons_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic [FILL_W-1:0] fill_q, fill_d;
   logic [VEC_W-1:0]  asm_q, asm_d;
   logic [VEC_W-1:0]  vec_q, vec_d;
   logic              valid_q, valid_d;
   logic              drop_q, drop_d;

   logic [VEC_W-1:0]  mem_q [NB_VECTORS];

   logic              fill_last;
   logic              accept;
   logic              push;
   logic              pop;
   logic [VEC_W-1:0]  asm_shift;

   assign fill_last = (fill_q == FILL_W'(BEATS - 1));
   assign full      = (count_q == CNT_W'(NB_VECTORS));
   assign empty     = (count_q == '0);

   // Only the completing beat has to wait for space; partial beats go on.
   assign in_ready  = !(full && fill_last);

   // New beat enters at the LSB side, so the first beat ends at the MSBs.
   // Written as a shift so IN_W == VEC_W needs no special slice.
   assign asm_shift = (asm_q << IN_W) | VEC_W'(in_data);

   assign accept    = in_valid && in_ready && !flush;
   assign push      = accept && fill_last;
   // Uses the pre-edge count, so a push in the same cycle cannot serve an
   // empty buffer.
   assign pop       = req && !empty && !flush;

   always_comb begin
      prod_d  = prod_q;
      cons_d  = cons_q;
      count_d = count_q;
      fill_d  = fill_q;
      asm_d   = asm_q;
      vec_d   = '0;
      valid_d = 1'b0;
      drop_d  = 1'b0;

      if (flush) begin
         prod_d  = '0;
         cons_d  = '0;
         count_d = '0;
         fill_d  = '0;
         asm_d   = '0;
      end else begin
         drop_d = in_valid && !in_ready;

         if (accept) begin
            asm_d = asm_shift;
            if (fill_last) begin
               fill_d = '0;
               prod_d = prod_q + PTR_W'(1);
            end else begin
               fill_d = fill_q + FILL_W'(1);
            end
         end

         if (pop) begin
            vec_d   = mem_q[cons_q];
            valid_d = 1'b1;
            cons_d  = cons_q + PTR_W'(1);
         end

         case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         prod_q  <= '0;
         cons_q  <= '0;
         count_q <= '0;
         fill_q  <= '0;
         asm_q   <= '0;
         vec_q   <= '0;
         valid_q <= 1'b0;
         drop_q  <= 1'b0;
      end else begin
         prod_q  <= prod_d;
         cons_q  <= cons_d;
         count_q <= count_d;
         fill_q  <= fill_d;
         asm_q   <= asm_d;
         vec_q   <= vec_d;
         valid_q <= valid_d;
         drop_q  <= drop_d;
      end
   end

   // Storage is not reset: an entry is only read after it has been written.
   always_ff @(posedge clk) begin
      if (!rst && push) begin
         mem_q[prod_q] <= asm_shift;
      end
   end

   assign vector = vec_q;
   assign valid  = valid_q;
   assign count  = count_q;
   assign drop   = drop_q;

endmodule

// File: tb/tb_vector_ring_buffer.sv
// ----------------------------------------------------------------------------
// tb_vector_ring_buffer
//   Instance A: VEC_W=8, NB_VECTORS=8, IN_W=1, checked every cycle against a
//   queue-based reference model. Instance B: VEC_W=8, NB_VECTORS=4, IN_W=4,
//   checked with directed expectations.
// ----------------------------------------------------------------------------
module tb_vector_ring_buffer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst;

   logic       a_flush, a_in_data, a_in_valid, a_req;
   logic       a_in_ready, a_valid, a_empty, a_full, a_drop;
   logic [7:0] a_vector;
   logic [3:0] a_count;

   logic       b_flush, b_in_valid, b_req;
   logic [3:0] b_in_data;
   logic       b_in_ready, b_valid, b_empty, b_full, b_drop;
   logic [7:0] b_vector;
   logic [2:0] b_count;

   vector_ring_buffer #(.VEC_W(8), .NB_VECTORS(8), .IN_W(1)) u_a (
      .clk(clk), .rst(rst), .flush(a_flush), .in_data(a_in_data),
      .in_valid(a_in_valid), .in_ready(a_in_ready), .req(a_req),
      .vector(a_vector), .valid(a_valid), .count(a_count),
      .empty(a_empty), .full(a_full), .drop(a_drop)
   );

   vector_ring_buffer #(.VEC_W(8), .NB_VECTORS(4), .IN_W(4)) u_b (
      .clk(clk), .rst(rst), .flush(b_flush), .in_data(b_in_data),
      .in_valid(b_in_valid), .in_ready(b_in_ready), .req(b_req),
      .vector(b_vector), .valid(b_valid), .count(b_count),
      .empty(b_empty), .full(b_full), .drop(b_drop)
   );

   int n_cmp = 0;
   int n_err = 0;

   // Reference model for instance A
   int unsigned mq[$];
   int unsigned mpart = 0;
   int unsigned mfill = 0;
   logic [7:0]  mvec  = 8'h00;
   logic        mvalid = 1'b0;
   logic        mdrop  = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic mready();
      return !(mq.size() == 8 && mfill == 7);
   endfunction

   // Advance one clock: update the model from the current inputs, then
   // compare every output of instance A shortly after the edge.
   task automatic tick();
      logic rdy;
      rdy = mready();
      if (rst) begin
         mq.delete();
         mpart = 0; mfill = 0; mvec = 8'h00; mvalid = 1'b0; mdrop = 1'b0;
      end else if (a_flush) begin
         mq.delete();
         mpart = 0; mfill = 0; mvec = 8'h00; mvalid = 1'b0; mdrop = 1'b0;
      end else begin
         mdrop = a_in_valid && !rdy;
         if (a_req && mq.size() > 0) begin
            mvec   = 8'(mq.pop_front());
            mvalid = 1'b1;
         end else begin
            mvec   = 8'h00;
            mvalid = 1'b0;
         end
         if (a_in_valid && rdy) begin
            mpart = ((mpart << 1) | 32'(a_in_data)) & 32'hFF;
            mfill++;
            if (mfill == 8) begin
               mq.push_back(mpart);
               mpart = 0;
               mfill = 0;
            end
         end
      end
      @(posedge clk);
      #1;
      chk("a_count",    32'(a_count),    32'(mq.size()));
      chk("a_empty",    32'(a_empty),    32'(mq.size() == 0));
      chk("a_full",     32'(a_full),     32'(mq.size() == 8));
      chk("a_valid",    32'(a_valid),    32'(mvalid));
      chk("a_vector",   32'(a_vector),   32'(mvec));
      chk("a_drop",     32'(a_drop),     32'(mdrop));
      chk("a_in_ready", 32'(a_in_ready), 32'(mready()));
      chk("a_count_le8", 32'(a_count <= 4'd8), 32'd1);
   endtask

   task automatic push_a(input logic [7:0] v, input int unsigned req_pct, input int unsigned gap_pct);
      int  b;
      int  tries;
      logic acc;
      b = 0;
      tries = 0;
      while (b < 8 && tries < 200) begin
         tries++;
         a_req = ($urandom_range(99) < req_pct);
         if ($urandom_range(99) < gap_pct) begin
            a_in_valid = 1'b0;
            tick();
         end else begin
            a_in_valid = 1'b1;
            a_in_data  = v[7-b];
            acc = a_in_ready;
            chk("a_in_ready_pre", 32'(a_in_ready), 32'(mready()));
            tick();
            if (acc) b++;
         end
      end
      a_in_valid = 1'b0;
      a_req      = 1'b0;
      chk("push_done", 32'(b), 32'd8);
   endtask

   task automatic pop_a();
      a_req = 1'b1;
      tick();
      a_req = 1'b0;
   endtask

   task automatic flush_a();
      a_flush = 1'b1;
      tick();
      a_flush = 1'b0;
   endtask

   initial begin
      logic [7:0] v;
      rst = 1'b1;
      a_flush = 1'b0; a_in_data = 1'b0; a_in_valid = 1'b0; a_req = 1'b0;
      b_flush = 1'b0; b_in_data = 4'h0; b_in_valid = 1'b0; b_req = 1'b0;
      tick();
      tick();
      rst = 1'b0;

      // Reset state
      chk("rst_vector",   32'(a_vector),   32'h00);
      chk("rst_valid",    32'(a_valid),    32'd0);
      chk("rst_drop",     32'(a_drop),     32'd0);
      chk("rst_empty",    32'(a_empty),    32'd1);
      chk("rst_full",     32'(a_full),     32'd0);
      chk("rst_in_ready", 32'(a_in_ready), 32'd1);
      chk("rst_b_empty",  32'(b_empty),    32'd1);
      chk("rst_b_ready",  32'(b_in_ready), 32'd1);

      // T1: beats 1,0,1,1,0,0,1,0 -> B2
      push_a(8'hB2, 0, 0);
      chk("t1_count", 32'(a_count), 32'd1);
      pop_a();
      chk("t1_vector", 32'(a_vector), 32'hB2);
      chk("t1_valid",  32'(a_valid),  32'd1);
      chk("t1_count0", 32'(a_count),  32'd0);
      chk("t1_empty",  32'(a_empty),  32'd1);

      // T2: fill, backpressure on completing beat, drain in order
      for (int i = 1; i <= 8; i++) push_a(8'(i), 0, 0);
      chk("t2_full",  32'(a_full),  32'd1);
      chk("t2_count", 32'(a_count), 32'd8);
      v = 8'h09;
      a_in_valid = 1'b1;
      for (int b = 0; b < 7; b++) begin
         a_in_data = v[7-b];
         chk("t2_partial_ready", 32'(a_in_ready), 32'd1);
         tick();
      end
      a_in_data = v[0];
      chk("t2_stall_ready", 32'(a_in_ready), 32'd0);
      tick();
      chk("t2_drop", 32'(a_drop), 32'd1);
      a_in_valid = 1'b0;
      tick();
      chk("t2_drop_clear", 32'(a_drop), 32'd0);
      for (int i = 1; i <= 8; i++) begin
         pop_a();
         chk("t2_pop_vector", 32'(a_vector), 32'(i));
         chk("t2_pop_valid",  32'(a_valid),  32'd1);
      end
      pop_a();
      chk("t2_empty_valid",  32'(a_valid),  32'd0);
      chk("t2_empty_vector", 32'(a_vector), 32'h00);
      flush_a();

      // T3: interleaved pushes/pops across pointer wrap
      for (int i = 0; i < 20; i++) push_a(8'h10 + 8'(i), 40, 20);
      for (int i = 0; i < 10; i++) pop_a();
      chk("t3_drained", 32'(a_empty), 32'd1);

      // T4: completing push and request in the same cycle
      flush_a();
      push_a(8'h3C, 0, 0);
      v = 8'h77;
      a_in_valid = 1'b1;
      for (int b = 0; b < 7; b++) begin
         a_in_data = v[7-b];
         tick();
      end
      a_in_data = v[0];
      a_req = 1'b1;
      tick();
      a_req = 1'b0;
      a_in_valid = 1'b0;
      chk("t4_vector", 32'(a_vector), 32'h3C);
      chk("t4_valid",  32'(a_valid),  32'd1);
      chk("t4_count",  32'(a_count),  32'd1);
      pop_a();
      chk("t4_vector2", 32'(a_vector), 32'h77);

      // T5: flush with 3 vectors and a partial vector pending
      for (int i = 0; i < 3; i++) push_a(8'($urandom), 0, 0);
      a_in_valid = 1'b1;
      for (int b = 0; b < 3; b++) begin
         a_in_data = 1'($urandom);
         tick();
      end
      chk("t5_count3", 32'(a_count), 32'd3);
      a_flush = 1'b1;
      a_req   = 1'b1;
      tick();
      a_flush = 1'b0;
      a_req   = 1'b0;
      a_in_valid = 1'b0;
      chk("t5_count", 32'(a_count), 32'd0);
      chk("t5_empty", 32'(a_empty), 32'd1);
      chk("t5_valid", 32'(a_valid), 32'd0);
      push_a(8'hE1, 0, 0);
      pop_a();
      chk("t5_vector", 32'(a_vector), 32'hE1);

      // Random traffic against the model
      for (int c = 0; c < 400; c++) begin
         a_in_valid = ($urandom_range(99) < 70);
         a_in_data  = 1'($urandom);
         a_req      = ($urandom_range(99) < 12);
         a_flush    = ($urandom_range(99) < 2);
         tick();
      end
      a_in_valid = 1'b0; a_req = 1'b0; a_flush = 1'b0;

      // T6: 4-bit beats on instance B, then reset in mid-operation
      b_in_valid = 1'b1;
      b_in_data  = 4'hA;
      tick();
      b_in_data  = 4'h5;
      tick();
      b_in_valid = 1'b0;
      b_req = 1'b1;
      tick();
      b_req = 1'b0;
      chk("t6_vector", 32'(b_vector), 32'hA5);
      chk("t6_valid",  32'(b_valid),  32'd1);
      b_in_valid = 1'b1;
      for (int b = 0; b < 5; b++) begin
         b_in_data = 4'(b + 1);
         tick();
      end
      b_in_valid = 1'b0;
      chk("t6_count2", 32'(b_count), 32'd2);
      rst = 1'b1;
      b_req = 1'b1;
      tick();
      rst = 1'b0;
      b_req = 1'b0;
      chk("t6_rst_count", 32'(b_count),    32'd0);
      chk("t6_rst_ready", 32'(b_in_ready), 32'd1);
      chk("t6_rst_valid", 32'(b_valid),    32'd0);
      chk("t6_rst_empty", 32'(b_empty),    32'd1);
      // The leftover beat must be gone: two fresh beats give a clean vector.
      b_in_valid = 1'b1;
      b_in_data  = 4'h3;
      tick();
      b_in_data  = 4'hC;
      tick();
      b_in_valid = 1'b0;
      b_req = 1'b1;
      tick();
      b_req = 1'b0;
      chk("t6_post_rst_vector", 32'(b_vector), 32'h3C);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
